// File: rtl/nms_frame_sched_if.sv
//==============================================================================
// nms_frame_sched_if : upstream commit and downstream frame-present handshakes
// Rev 1.0
//==============================================================================
`default_nettype none

interface nms_frame_sched_if;
   logic in_valid;
   logic in_ready;
   logic in_slot;
   logic out_valid;
   logic out_ready;
   logic out_slot;
   logic out_pass;
   logic out_timeout;

   modport master (
      output in_valid, out_ready,
      input  in_ready, in_slot, out_valid, out_slot, out_pass, out_timeout
   );

   modport slave (
      input  in_valid, out_ready,
      output in_ready, in_slot, out_valid, out_slot, out_pass, out_timeout
   );
endinterface

`default_nettype wire

// File: rtl/nms_frame_sched.sv
//==============================================================================
// nms_frame_sched : ping-pong frame scheduler, watchdog and stats for NMS LDPC
// Rev 1.0
//==============================================================================
`default_nettype none

module nms_frame_sched #(
   parameter int MAX_CYC = 4096,
   parameter int CW      = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   nms_frame_sched_if.slave    fs,
   output logic                buf_sel,
   output logic                start_nms,
   input  logic                finish_nms,
   input  logic                flag_reg,
   output logic                dec_abort,
   output logic                busy,
   output logic [CW-1:0]       frame_cnt,
   output logic [CW-1:0]       fail_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [CW-1:0] C_WD_LAST = CW'(MAX_CYC - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_full;
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic          r_live;
   logic [CW-1:0] r_cyc;
   logic [CW-1:0] r_frame_cnt;
   logic [CW-1:0] r_fail_cnt;
   logic          r_pass;
   logic          r_timeout;

   logic          w_commit;
   logic          w_release;
   logic          w_wd_hit;
   logic          w_done;
   logic          w_fail;

   assign w_commit  = fs.in_valid & fs.in_ready;
   assign w_release = (r_state == HOLD) & fs.out_ready;
   assign w_wd_hit  = (r_cyc == C_WD_LAST);
   assign w_done    = (r_state == RUN) & (finish_nms | w_wd_hit);
   // A finish in the watchdog cycle takes priority, so flag_reg decides pass/fail.
   assign w_fail    = finish_nms ? ~flag_reg : 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      start_nms   = 1'b0;
      dec_abort   = 1'b0;
      case (r_state)
         IDLE:  if (en && r_full[r_rd_ptr]) w_state_nxt = START;
         START: begin
            start_nms   = 1'b1;
            w_state_nxt = RUN;
         end
         RUN: begin
            if (finish_nms) begin
               w_state_nxt = HOLD;
            end else if (w_wd_hit) begin
               dec_abort   = 1'b1;
               w_state_nxt = HOLD;
            end
         end
         HOLD:  if (fs.out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_full      <= 2'b00;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_live      <= 1'b0;
         r_cyc       <= '0;
         r_frame_cnt <= '0;
         r_fail_cnt  <= '0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
         // A commit and a release never address the same slot: commit needs
         // an empty slot, release targets the full one being presented.
         if (w_commit) begin
            r_full[r_wr_ptr] <= 1'b1;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_release) begin
            r_full[r_rd_ptr] <= 1'b0;
            r_rd_ptr         <= ~r_rd_ptr;
         end
         if (r_state == START)
            r_cyc <= '0;
         else if (r_state == RUN)
            r_cyc <= r_cyc + 1'b1;
         if (w_done) begin
            r_pass    <= finish_nms & flag_reg;
            r_timeout <= ~finish_nms;
            if (r_frame_cnt != '1)
               r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_fail && (r_fail_cnt != '1))
               r_fail_cnt <= r_fail_cnt + 1'b1;
         end
      end
   end

   assign fs.in_ready    = r_live & ~r_full[r_wr_ptr];
   assign fs.in_slot     = r_wr_ptr;
   assign fs.out_valid   = (r_state == HOLD);
   assign fs.out_slot    = r_rd_ptr;
   assign fs.out_pass    = r_pass;
   assign fs.out_timeout = r_timeout;
   assign buf_sel        = r_rd_ptr;
   assign busy           = (r_state != IDLE);
   assign frame_cnt      = r_frame_cnt;
   assign fail_cnt       = r_fail_cnt;

endmodule

`default_nettype wire

// File: tb/tb_nms_frame_sched.sv
//==============================================================================
// tb_nms_frame_sched : directed self-checking bench for nms_frame_sched
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_nms_frame_sched;
   localparam int MAX_CYC = 16;
   localparam int CW      = 16;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          buf_sel;
   logic          start_nms;
   logic          finish_nms;
   logic          flag_reg;
   logic          dec_abort;
   logic          busy;
   logic [CW-1:0] frame_cnt;
   logic [CW-1:0] fail_cnt;

   int n_checks   = 0;
   int n_failures = 0;

   nms_frame_sched_if bus();

   nms_frame_sched #(.MAX_CYC(MAX_CYC), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .fs         (bus),
      .buf_sel    (buf_sel),
      .start_nms  (start_nms),
      .finish_nms (finish_nms),
      .flag_reg   (flag_reg),
      .dec_abort  (dec_abort),
      .busy       (busy),
      .frame_cnt  (frame_cnt),
      .fail_cnt   (fail_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int  n;
      logic seen_start;
      logic seen_sel_chg;

      rst_n = 1'b0; en = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      finish_nms = 1'b0; flag_reg = 1'b0;
      #1;
      check_eq("rst_in_ready", bus.in_ready, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_outs", {start_nms, dec_abort, bus.out_valid, buf_sel, bus.in_slot}, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_in_ready", bus.in_ready, 1);
      check_eq("post_rst_cnts", {frame_cnt, fail_cnt}, 0);

      // Frame 1: slot 0, pass
      bus.in_valid = 1'b1; tick(); bus.in_valid = 1'b0;
      check_eq("t1_in_slot", bus.in_slot, 1);
      check_eq("t1_no_start_yet", start_nms, 0);
      tick();
      check_eq("t1_start", start_nms, 1);
      check_eq("t1_buf_sel", buf_sel, 0);
      tick();
      check_eq("t1_start_one_cycle", start_nms, 0);
      en = 1'b0; repeat (5) tick(); en = 1'b1;
      check_eq("t1_en_low_keeps_run", busy, 1);
      finish_nms = 1'b1; flag_reg = 1'b1; tick(); finish_nms = 1'b0; flag_reg = 1'b0;
      check_eq("t1_out_valid", bus.out_valid, 1);
      check_eq("t1_pass_to", {bus.out_pass, bus.out_timeout}, 2'b10);
      check_eq("t1_frame_cnt", frame_cnt, 1);
      check_eq("t1_fail_cnt", fail_cnt, 0);
      check_eq("t1_out_slot", bus.out_slot, 0);
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      check_eq("t1_idle", {busy, bus.out_valid}, 0);
      check_eq("t1_ptrs", {buf_sel, bus.in_slot}, 2'b11);
      finish_nms = 1'b1; tick(); finish_nms = 1'b0;
      check_eq("t1_stray_finish_idle", frame_cnt, 1);

      // Frames 2/3: back-to-back commits into slots 1 and 0
      bus.in_valid = 1'b1; tick(); tick(); bus.in_valid = 1'b0;
      check_eq("t2_in_ready_full", bus.in_ready, 0);
      check_eq("t2_start", start_nms, 1);
      check_eq("t2_buf_sel", buf_sel, 1);
      bus.in_valid = 1'b1; tick(); bus.in_valid = 1'b0;
      check_eq("t2_reject_commit", {bus.in_ready, bus.in_slot}, 2'b01);
      repeat (3) tick();
      finish_nms = 1'b1; flag_reg = 1'b0; tick(); finish_nms = 1'b0;
      check_eq("t2_fail_capture", {bus.out_valid, bus.out_pass, bus.out_timeout}, 3'b100);
      check_eq("t2_cnts", {frame_cnt, fail_cnt}, {16'd2, 16'd1});
      check_eq("t2_out_slot", bus.out_slot, 1);

      // Stalled HOLD with the other slot full
      seen_start = 1'b0; seen_sel_chg = 1'b0;
      for (int i = 0; i < 50; i++) begin
         finish_nms = (i % 7 == 3);
         flag_reg   = (i % 2 == 0);
         tick();
         seen_start   = seen_start | start_nms;
         seen_sel_chg = seen_sel_chg | (buf_sel != 1'b1);
      end
      finish_nms = 1'b0;
      check_eq("t5_no_start", seen_start, 0);
      check_eq("t5_buf_sel_stable", seen_sel_chg, 0);
      check_eq("t5_cnts_unchanged", {frame_cnt, fail_cnt}, {16'd2, 16'd1});
      check_eq("t5_still_hold", bus.out_valid, 1);
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      check_eq("t2_gap_cycle", {start_nms, busy}, 0);
      tick();
      check_eq("t2_second_start", start_nms, 1);
      check_eq("t2_second_buf_sel", buf_sel, 0);
      check_eq("t2_commit_target", {bus.in_ready, bus.in_slot}, 2'b11);

      // Commit during RUN, then let the watchdog fire
      bus.in_valid = 1'b1; tick(); bus.in_valid = 1'b0;
      check_eq("t3_full_after_commit", {bus.in_ready, bus.in_slot}, 2'b00);
      n = 1;
      while (dec_abort !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check_eq("t3_abort_latency", n, 16);
      check_eq("t3_abort_no_valid", bus.out_valid, 0);
      tick();
      check_eq("t3_abort_one_cycle", dec_abort, 0);
      check_eq("t3_timeout_capture", {bus.out_valid, bus.out_pass, bus.out_timeout}, 3'b101);
      check_eq("t3_cnts", {frame_cnt, fail_cnt}, {16'd3, 16'd2});
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

      // Finish lands in the watchdog cycle
      tick();
      check_eq("t4_start", {start_nms, buf_sel}, 2'b11);
      repeat (16) tick();
      finish_nms = 1'b1; flag_reg = 1'b1;
      #1;
      check_eq("t4_no_abort", dec_abort, 0);
      tick(); finish_nms = 1'b0; flag_reg = 1'b0;
      check_eq("t4_capture", {bus.out_valid, bus.out_pass, bus.out_timeout}, 3'b110);
      check_eq("t4_cnts", {frame_cnt, fail_cnt}, {16'd4, 16'd2});
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

      // en low with a frame pending
      en = 1'b0;
      bus.in_valid = 1'b1; tick(); bus.in_valid = 1'b0;
      seen_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         seen_start = seen_start | start_nms | busy;
      end
      check_eq("t6_en_low_idle", seen_start, 0);
      check_eq("t6_pending_slot", {bus.in_ready, bus.in_slot, buf_sel}, 3'b110);
      en = 1'b1; tick();
      check_eq("t6_en_start", start_nms, 1);

      // Asynchronous reset in the watchdog cycle
      repeat (16) tick();
      check_eq("t6_abort_before_rst", dec_abort, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_rst_pulses", {start_nms, dec_abort}, 0);
      check_eq("t6_rst_state", {busy, bus.out_valid, bus.in_ready, bus.in_slot, buf_sel}, 0);
      check_eq("t6_rst_cnts", {frame_cnt, fail_cnt}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("t6_post_rst_ready", {bus.in_ready, busy}, 2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end
endmodule

`default_nettype wire
